// File: rtl/rf_up_stream_ctrl.sv
// Start/stop sequencer for one channel of the 2-to-4 RF up-sampling path.
// Define RF_UP_CTRL_UNDERRUN_CNT_EN to build the saturating underrun counter.
module rf_up_stream_ctrl #(
    parameter int PRIME_CYCLES = 32,
    parameter int DRAIN_CYCLES = 32,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ctrl_enable,
    output logic [1:0]         ctrl_status,
    output logic               busy,
    input  logic [63:0]        i_tdata,
    input  logic               i_tvalid,
    output logic [63:0]        dp_tdata,
    output logic               dp_tvalid,
    input  logic [127:0]       dp_o_tdata,
    input  logic               dp_o_tvalid,
    output logic [127:0]       o_tdata,
    output logic               o_tvalid,
    input  logic               underrun_clear,
    output logic [CNT_W-1:0]   underrun_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int MAX_CYC = (PRIME_CYCLES > DRAIN_CYCLES) ? PRIME_CYCLES : DRAIN_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TMR_W-1:0] PRIME_LOAD = TMR_W'(PRIME_CYCLES - 1);
    localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES - 1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [63:0]        dp_tdata_q;
    logic               dp_tvalid_q;
    logic [127:0]       o_tdata_q;
    logic               o_tvalid_q;
    logic               out_open;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            IDLE: begin
                if (ctrl_enable) begin
                    state_d = PRIME;
                    tmr_d   = PRIME_LOAD;
                end
            end
            PRIME: begin
                if (tmr_q == '0) begin
                    state_d = RUN;
                end else if (!ctrl_enable) begin
                    state_d = DRAIN;
                    tmr_d   = DRAIN_LOAD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            RUN: begin
                if (!ctrl_enable) begin
                    state_d = DRAIN;
                    tmr_d   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (tmr_q == '0) state_d = IDLE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Input side looks ahead at the next state so the first user word lands on the RUN-entry edge.
    assign out_open = (state_q == RUN) || (state_q == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_tvalid_q <= 1'b0;
            dp_tdata_q  <= '0;
            o_tvalid_q  <= 1'b0;
            o_tdata_q   <= '0;
        end else begin
            dp_tvalid_q <= (state_d != IDLE);
            dp_tdata_q  <= (state_d == RUN && i_tvalid) ? i_tdata : '0;
            o_tvalid_q  <= dp_o_tvalid && out_open;
            o_tdata_q   <= (dp_o_tvalid && out_open) ? dp_o_tdata : '0;
        end
    end

`ifdef RF_UP_CTRL_UNDERRUN_CNT_EN
    logic [CNT_W-1:0] underrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= '0;
        end else if (underrun_clear) begin
            underrun_q <= '0;
        end else if (state_q == RUN && ctrl_enable && !i_tvalid && underrun_q != '1) begin
            underrun_q <= underrun_q + 1'b1;
        end
    end

    assign underrun_count = underrun_q;
`else
    logic unused_underrun_clear;
    assign unused_underrun_clear = underrun_clear;
    assign underrun_count        = '0;
`endif

    assign ctrl_status = state_q;
    assign busy        = (state_q != IDLE);
    assign dp_tdata    = dp_tdata_q;
    assign dp_tvalid   = dp_tvalid_q;
    assign o_tdata     = o_tdata_q;
    assign o_tvalid    = o_tvalid_q;

endmodule

// File: doc/rf_up_stream_ctrl.md
# rf_up_stream_ctrl

Start/stop sequencer for one channel of the 2-to-4 RF up-sampling path. It sits in front of the up-sampler, on the same clock as its 2 SPC input. On enable, it primes the half-band filter with zeros. It then streams user samples continuously, inserting zeros on underrun. On disable, it drains the filter tail with zeros. Up-sampler output is masked until the pipeline holds only known samples.

## Interface
- PRIME_CYCLES, 32, zero-fill cycles before user data is passed; ≥1 and ≥ up-sampler latency.
- DRAIN_CYCLES, 32, zero-fill cycles after disable; ≥1.
- CNT_W, 16, underrun counter width.

- clk  in  1  sample clock (1x domain of the up-sampler).
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ctrl_enable  in  1  level request to stream.
- ctrl_status  out  2  state: IDLE=0, PRIME=1, RUN=2, DRAIN=3.
- busy  out  1  state != IDLE.
- i_tdata  in  64  user samples, 2 SPC.
- i_tvalid  in  1  user sample valid; no backpressure.
- dp_tdata  out  64  to up-sampler input.
- dp_tvalid  out  1  to up-sampler input valid.
- dp_o_tdata  in  128  up-sampler output, 4 SPC.
- dp_o_tvalid  in  1  up-sampler output valid.
- o_tdata  out  128  gated output, 4 SPC.
- o_tvalid  out  1  gated output valid.
- underrun_clear  in  1  synchronous clear of underrun_count.
- underrun_count  out  CNT_W  saturating count of RUN cycles with no input.

## Operation
- FSM transitions:
  - IDLE: ctrl_enable=1 → PRIME; counter loads PRIME_CYCLES-1.
  - PRIME: counter==0 → RUN; ctrl_enable=0 → DRAIN with counter loaded DRAIN_CYCLES-1 (abort); otherwise decrement.
  - RUN: ctrl_enable=0 → DRAIN; counter loads DRAIN_CYCLES-1.
  - DRAIN: counter==0 → IDLE; otherwise decrement. ctrl_enable is ignored in DRAIN. If it is still high on reaching IDLE, the block enters PRIME on the next edge.
- Input gating, all registered, using next_state (ns):
  - dp_tvalid <= (ns != IDLE). The filter is fed every cycle while not idle.
  - dp_tdata <= (ns==RUN && i_tvalid) ? i_tdata : 0.
- Output gating, registered, using current state:
  - o_tvalid <= dp_o_tvalid && (state==RUN || state==DRAIN).
  - o_tdata <= same condition ? dp_o_tdata : 0.
  - Output is fully masked in IDLE and PRIME.
- Underrun: an underrun is any edge with state==RUN, ctrl_enable=1 and i_tvalid=0. It increments underrun_count.
  - Saturates at 2^CNT_W-1.
  - underrun_clear has priority over a simultaneous increment: the result is 0.
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, and every output is 0 (dp_*, o_*, underrun_count, ctrl_status, busy).
  - Reset mid-stream drops all in-flight data; no drain is performed.

## Timing
- i_tdata → dp_tdata: 1 cycle.
- dp_o_tdata → o_tdata: 1 cycle.
- ctrl_enable sampled high at edge N in IDLE: ctrl_status=1 and dp_tvalid=1 after edge N.
- PRIME lasts exactly PRIME_CYCLES cycles. The first user word is i_tdata sampled at the edge that enters RUN.
- DRAIN lasts exactly DRAIN_CYCLES cycles. dp_tvalid falls after the edge that enters IDLE.
- Minimum IDLE→IDLE round trip with a 1-cycle enable pulse: 1 PRIME cycle + DRAIN_CYCLES.
- ctrl_status and busy reflect the registered state; there is no combinational path from inputs to outputs.

## Configuration
- RF_UP_CTRL_UNDERRUN_CNT_EN defined: the underrun counter and underrun_clear are implemented as described.
- Not defined: underrun_count is tied to 0, underrun_clear is ignored, and no counter logic is synthesized. All other behaviour is identical.

## Test plan
- Prime, PRIME_CYCLES=4: assert ctrl_enable with i_tvalid=1 and incrementing data.
  - Expect dp_tvalid high with dp_tdata=0 for 4 cycles.
  - Then dp_tdata=first sample 1 cycle after its input.
  - o_tvalid=0 throughout PRIME.
- Underrun: in RUN, drop i_tvalid for 3 cycles.
  - Expect dp_tdata=0 for those 3 cycles, dp_tvalid held 1, underrun_count=3.
  - Pulse underrun_clear together with a 4th underrun: count=0.
- Saturation, CNT_W=4: 20 underrun cycles → underrun_count=15.
- Drain, DRAIN_CYCLES=5: deassert ctrl_enable in RUN.
  - Expect 5 cycles of dp_tdata=0 with o_tvalid following dp_o_tvalid.
  - Then IDLE, ctrl_status=0, dp_tvalid=0.
- Enable during DRAIN: toggle ctrl_enable 1→0→1 in RUN.
  - Expect the full DRAIN_CYCLES, one IDLE cycle, then PRIME.
- Async reset: assert rst_n=0 mid-RUN, between clock edges.
  - All outputs go to 0 immediately and ctrl_status=0.
  - After release with ctrl_enable=1, PRIME starts on the next edge.
- Macro: build without RF_UP_CTRL_UNDERRUN_CNT_EN and repeat the underrun test; underrun_count stays 0.
